// File: rtl/i2c_target.sv
`default_nettype none
// -------------------------------------------------------------------------
// i2c_target - oversampled I2C target: 7-bit address match, write strobe,
// read request. Optional SCL stretching: I2C_TARGET_CLOCK_STRETCH_EN. Rev 1.0
// -------------------------------------------------------------------------
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR     = 7'h42,
  parameter int         SYNC_STAGES     = 2,
  parameter int         FILTER_CYCLES   = 4,
  parameter int         SDA_HOLD_CYCLES = 30
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        scl_pin,
  inout  wire        sda_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic       rx_ready,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       addressed,
  output logic       start_det,
  output logic       stop_det,
  output logic       master_nack
);
  localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int HW = (SDA_HOLD_CYCLES > 1) ? $clog2(SDA_HOLD_CYCLES) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(SDA_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
  } state_t;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]                  raw, filt, filt_d;
  logic [1:0][SYNC_STAGES-1:0] sync;
  logic [1:0][FW-1:0]          fcnt;

  assign raw = {sda_pin, scl_pin};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync   <= '1;
      filt   <= '1;
      filt_d <= '1;
      fcnt   <= '0;
    end else begin
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        sync[i] <= {sync[i][SYNC_STAGES-2:0], raw[i]};
        if (sync[i][SYNC_STAGES-1] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_LAST) begin
          filt[i] <= sync[i][SYNC_STAGES-1];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  logic sda_f, scl_rise, scl_fall, start_c, stop_c;
  assign sda_f    = filt[1];
  assign scl_rise = filt[0] & ~filt_d[0];
  assign scl_fall = ~filt[0] & filt_d[0];
  assign start_c  = ~filt[1] & filt_d[1] & filt[0] & filt_d[0];
  assign stop_c   = filt[1] & ~filt_d[1] & filt[0] & filt_d[0];

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [6:0]    shreg;
  logic [7:0]    tx_byte;
  logic          rw, first, ack_ok, sda_oe, sda_next, hold_act;
  logic [HW-1:0] hold_cnt;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  logic          scl_oe, hold_rel, waiting;
`endif

  // SDA level to present once the hold time after an SCL fall has elapsed
  always_comb begin
    sda_next = 1'b0;
    case (state)
      ADDR_ACK:  sda_next = 1'b1;
      WRITE_ACK: sda_next = ack_ok;
      READ:      sda_next = ~tx_byte[3'd7 - bit_cnt[2:0]];
      default:   sda_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      tx_byte     <= '0;
      rw          <= 1'b0;
      first       <= 1'b0;
      ack_ok      <= 1'b0;
      sda_oe      <= 1'b0;
      hold_act    <= 1'b0;
      hold_cnt    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_first    <= 1'b0;
      tx_req      <= 1'b0;
      addressed   <= 1'b0;
      start_det   <= 1'b0;
      stop_det    <= 1'b0;
      master_nack <= 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      scl_oe      <= 1'b0;
      hold_rel    <= 1'b0;
      waiting     <= 1'b0;
`endif
    end else begin
      rx_valid    <= 1'b0;
      rx_first    <= 1'b0;
      tx_req      <= 1'b0;
      start_det   <= 1'b0;
      stop_det    <= 1'b0;
      master_nack <= 1'b0;
`ifndef I2C_TARGET_CLOCK_STRETCH_EN
      if (tx_req)   tx_byte <= tx_data;
      if (rx_valid) ack_ok  <= rx_ready;
`endif
      if (hold_act) begin
        if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - 1'b1;
        end else begin
          hold_act <= 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
          if (hold_rel) scl_oe <= 1'b0;
          else          sda_oe <= sda_next;
`else
          sda_oe <= sda_next;
`endif
        end
      end
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      // SDA is set up first, SCL is let go one hold time later
      if (waiting && ((state == READ) ? tx_valid : rx_ready)) begin
        waiting  <= 1'b0;
        hold_act <= 1'b1;
        hold_rel <= 1'b1;
        hold_cnt <= HOLD_LOAD;
        if (state == READ) begin
          tx_byte <= tx_data;
          sda_oe  <= ~tx_data[7];
        end else begin
          ack_ok <= 1'b1;
          sda_oe <= 1'b1;
        end
      end
`endif
      if (scl_rise) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {shreg[5:0], sda_f};
        case (state)
          ADDR: if (bit_cnt == 4'd7) begin
            if (shreg == TARGET_ADDR) begin
              state     <= ADDR_ACK;
              addressed <= 1'b1;
              rw        <= sda_f;
            end else begin
              state <= IGNORE;
            end
          end
          ADDR_ACK: if (rw) tx_req <= 1'b1;
          WRITE: if (bit_cnt == 4'd7) begin
            rx_data  <= {shreg, sda_f};
            rx_valid <= 1'b1;
            rx_first <= first;
            first    <= 1'b0;
            state    <= WRITE_ACK;
          end
          READ: if (bit_cnt == 4'd7) state <= READ_ACK;
          READ_ACK: begin
            if (sda_f) begin
              master_nack <= 1'b1;
              state       <= IGNORE;
            end else begin
              tx_req <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (scl_fall) begin
        hold_act <= 1'b1;
        hold_cnt <= HOLD_LOAD;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
        hold_rel <= 1'b0;
        if ((state == WRITE_ACK && bit_cnt == 4'd8) ||
            (((state == ADDR_ACK && rw) || state == READ_ACK) && bit_cnt == 4'd9)) begin
          scl_oe   <= 1'b1;
          waiting  <= 1'b1;
          hold_act <= 1'b0;
        end
`endif
        if (bit_cnt == 4'd9) begin
          bit_cnt <= '0;
          case (state)
            ADDR_ACK: begin
              state <= rw ? READ : WRITE;
              first <= 1'b1;
            end
            WRITE_ACK: state <= ack_ok ? WRITE : IGNORE;
            READ_ACK:  state <= READ;
            default: ;
          endcase
        end
      end
      if (start_c || stop_c) begin
        state     <= start_c ? ADDR : IDLE;
        bit_cnt   <= '0;
        start_det <= start_c;
        stop_det  <= stop_c;
        addressed <= 1'b0;
        sda_oe    <= 1'b0;
        hold_act  <= 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
        scl_oe    <= 1'b0;
        waiting   <= 1'b0;
`endif
      end
    end
  end

  assign sda_pin = sda_oe ? 1'b0 : 1'bz;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  assign scl_pin = scl_oe ? 1'b0 : 1'bz;
`else
  logic unused_tx_valid;
  assign unused_tx_valid = tx_valid;
  assign scl_pin = 1'bz;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// tb_i2c_target - bit-banged I2C master against i2c_target with scoreboards.
module tb_i2c_target;
  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1, m_sda = 1'b1;
  wire        scl_bus, sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first, tx_req, addressed, start_det, stop_det, master_nack;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  assign scl_bus = m_scl ? 1'bz : 1'b0;
  assign sda_bus = m_sda ? 1'bz : 1'b0;
  pullup (scl_bus);
  pullup (sda_bus);

  i2c_target dut (
    .clk(clk), .reset(reset), .scl_pin(scl_bus), .sda_pin(sda_bus),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first), .rx_ready(rx_ready),
    .tx_req(tx_req), .tx_data(tx_data), .tx_valid(tx_valid), .addressed(addressed),
    .start_det(start_det), .stop_det(stop_det), .master_nack(master_nack)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int checks = 0, errors = 0;
  int rx_cnt, tx_cnt, nack_cnt, sdet_cnt, pdet_cnt, drive_cnt, addr_seen;
  int tx_delay = 0, tx_wait = 0, low_run = 0, low_max = 0;
  logic [8:0] rx_exp[$];
  logic [7:0] tx_src[$], rd_exp[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    rx_cnt = 0; tx_cnt = 0; nack_cnt = 0; sdet_cnt = 0; pdet_cnt = 0;
    drive_cnt = 0; addr_seen = 0; low_max = 0;
  endtask

  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sda_bus === 1'b0 && m_sda) drive_cnt++;
        if (addressed) addr_seen = 1;
        if (start_det) sdet_cnt++;
        if (stop_det) pdet_cnt++;
        if (master_nack) nack_cnt++;
        if (scl_bus === 1'b0) low_run++;
        else begin
          if (low_run > low_max) low_max = low_run;
          low_run = 0;
        end
        if (rx_valid || tx_req || master_nack)
          check("exclusive", 32'(rx_valid) + 32'(tx_req) + 32'(master_nack), 1);
        if (rx_valid) begin
          rx_cnt++;
          if (rx_exp.size() == 0) check("rx_unexpected", {rx_first, rx_data}, 32'h200);
          else begin
            e = rx_exp.pop_front();
            check("rx_byte", {rx_first, rx_data}, e);
          end
        end
        if (tx_req) begin
          tx_cnt++;
          if (tx_src.size() == 0) check("tx_unexpected", tx_cnt, 0);
          else tx_data = tx_src.pop_front();
          tx_valid = (tx_delay == 0);
          tx_wait  = tx_delay;
        end else if (tx_wait > 0) begin
          tx_wait--;
          if (tx_wait == 0) tx_valid = 1'b1;
        end
      end
    end
  endtask

  task automatic scl_release();
    int n = 0;
    m_scl = 1'b1;
    while (scl_bus !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("scl_stuck_low", scl_bus, 1);
  endtask

  task automatic send_bit(input logic b, input logic glitch, output logic seen);
    tick(10);
    m_sda = b;
    tick(Q - 10);
    scl_release();
    tick(Q / 2);
    seen = sda_bus;
    if (glitch) begin
      tick(Q / 4);
      m_scl = 1'b0;
      tick(2);
      m_scl = 1'b1;
      tick(Q / 4 - 2);
    end else begin
      tick(Q / 2);
    end
    m_scl = 1'b0;
  endtask

  task automatic bus_start();
    tick(10);
    m_sda = 1'b1;
    tick(Q);
    scl_release();
    tick(Q);
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(10);
    m_sda = 1'b0;
    tick(Q);
    scl_release();
    tick(Q);
    m_sda = 1'b1;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input int gl, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == gl, s);
    send_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, s);
      b[i] = s;
    end
    send_bit(nack, 1'b0, s);
  endtask

  initial begin
    logic       a;
    logic [7:0] b;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {rx_data, rx_valid, rx_first, tx_req, addressed, start_det, stop_det, master_nack}, 0);
    check("reset_sda", sda_bus, 1);
    tick(1);
    reset = 1'b0;
    tick(20);

    // write two data bytes
    clear_counts();
    bus_start();
    write_byte(8'h84, -1, a);  check("w_addr_ack", a, 0);
    rx_exp.push_back({1'b1, 8'hA5});
    write_byte(8'hA5, -1, a);  check("w_ack1", a, 0);
    rx_exp.push_back({1'b0, 8'h3C});
    write_byte(8'h3C, -1, a);  check("w_ack2", a, 0);
    check("w_addressed", addressed, 1);
    bus_stop();
    tick(20);
    check("w_addressed_off", addressed, 0);
    check("w_rx_cnt", rx_cnt, 2);
    check("w_start_cnt", sdet_cnt, 1);
    check("w_stop_cnt", pdet_cnt, 1);
    check("w_rx_left", rx_exp.size(), 0);

    // read two bytes, ACK then NACK
    clear_counts();
    tx_src.push_back(8'hC3); rd_exp.push_back(8'hC3);
    tx_src.push_back(8'h5A); rd_exp.push_back(8'h5A);
    bus_start();
    write_byte(8'h85, -1, a);  check("r_addr_ack", a, 0);
    read_byte(1'b0, b);        check("r_byte1", b, rd_exp.pop_front());
    read_byte(1'b1, b);        check("r_byte2", b, rd_exp.pop_front());
    tick(Q / 2);
    check("r_sda_released", sda_bus, 1);
    bus_stop();
    tick(20);
    check("r_tx_req_cnt", tx_cnt, 2);
    check("r_nack_cnt", nack_cnt, 1);
    check("r_rx_cnt", rx_cnt, 0);

    // address miss
    clear_counts();
    bus_start();
    write_byte(8'hA0, -1, a);  check("m_addr_nack", a, 1);
    write_byte(8'h11, -1, a);  check("m_data_nack", a, 1);
    bus_stop();
    tick(20);
    check("m_sda_driven", drive_cnt, 0);
    check("m_rx_tx", rx_cnt + tx_cnt, 0);
    check("m_addressed", addr_seen, 0);
    check("m_stop_cnt", pdet_cnt, 1);

    // repeated START: write one byte then read one byte
    clear_counts();
    bus_start();
    write_byte(8'h84, -1, a);  check("rs_w_ack", a, 0);
    rx_exp.push_back({1'b1, 8'h07});
    write_byte(8'h07, -1, a);  check("rs_d_ack", a, 0);
    tx_src.push_back(8'h99); rd_exp.push_back(8'h99);
    bus_start();
    write_byte(8'h85, -1, a);  check("rs_r_ack", a, 0);
    read_byte(1'b1, b);        check("rs_byte", b, rd_exp.pop_front());
    bus_stop();
    tick(20);
    check("rs_start_cnt", sdet_cnt, 2);
    check("rs_tx_cnt", tx_cnt, 1);
    check("rs_rx_cnt", rx_cnt, 1);
    check("rs_idle", 32'(dut.state), 0);

`ifndef I2C_TARGET_CLOCK_STRETCH_EN
    // user refuses a byte: NACK, then the rest of the transfer is ignored
    clear_counts();
    rx_ready = 1'b0;
    bus_start();
    write_byte(8'h84, -1, a);  check("n_addr_ack", a, 0);
    rx_exp.push_back({1'b1, 8'hEE});
    write_byte(8'hEE, -1, a);  check("n_nack", a, 1);
    write_byte(8'h12, -1, a);  check("n_ignored", a, 1);
    bus_stop();
    tick(20);
    rx_ready = 1'b1;
    check("n_rx_cnt", rx_cnt, 1);
`endif

    // glitch inside an SCL high phase must not add a bit
    clear_counts();
    bus_start();
    write_byte(8'h84, -1, a);  check("g_addr_ack", a, 0);
    rx_exp.push_back({1'b1, 8'h5A});
    write_byte(8'h5A, 3, a);   check("g_ack", a, 0);
    bus_stop();
    tick(20);
    check("g_rx_cnt", rx_cnt, 1);

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    // read data withheld: SCL held low until tx_valid
    clear_counts();
    tx_delay = 200;
    tx_src.push_back(8'h96); rd_exp.push_back(8'h96);
    bus_start();
    write_byte(8'h85, -1, a);  check("s_addr_ack", a, 0);
    read_byte(1'b1, b);        check("s_byte", b, rd_exp.pop_front());
    bus_stop();
    tick(20);
    check("s_low_stretched", 32'(low_max >= Q + 25 && low_max <= Q + 80), 1);
    tx_delay = 0;
`endif

    // reset in the middle of a read byte while SDA is driven low
    clear_counts();
    tx_src.push_back(8'h00);
    bus_start();
    write_byte(8'h85, -1, a);  check("x_addr_ack", a, 0);
    send_bit(1'b1, 1'b0, a);
    send_bit(1'b1, 1'b0, a);
    tick(Q / 2);
    check("x_sda_low", sda_bus, 0);
    check("x_addressed", addressed, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("x_sda_released", sda_bus, 1);
    check("x_outs", {rx_data, rx_valid, rx_first, tx_req, addressed, start_det, stop_det, master_nack}, 0);
    tick(2);
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
